// File: rtl/nios_fast_oci_mon_responder.sv
// ============================================================================
// Module  : nios_fast_oci_mon_responder
// Brief   : clk-domain OCI monitor-memory responder; executes JTAG-issued word
//           reads/writes on the debug-memory master port. Optional access
//           timeout is enabled by defining OCI_MON_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nios_fast_oci_mon_responder #(
  parameter int ADDR_W         = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_READ  = 2'd1;
  localparam logic [1:0]  S_WRITE = 2'd2;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mon_q, mon_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;

  logic w_req;
  logic w_any_strobe;
  logic w_accept;
  logic w_timeout;

  assign w_req        = read_q | write_q;
  assign w_any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_accept     = w_req & ~mem_waitrequest;

`ifdef OCI_MON_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts stalled cycles already seen; the TIMEOUT_CYCLES-th stall aborts.
  assign w_timeout = w_req & mem_waitrequest & (cnt_q == TO_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
    end else if (w_req && mem_waitrequest) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign w_timeout = 1'b0;
  logic w_unused_to;
  assign w_unused_to = &{1'b0, TO_LAST};
`endif

  logic w_unused_jdo;
  assign w_unused_jdo = &{1'b0, jdo[37:35], jdo[1]};

  // State and registered-output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wdata_q <= '0;
      mon_q   <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      read_q  <= read_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      mon_q   <= mon_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_b) begin
          state_d = S_WRITE;
        end else if (take_action_ocimem_a) begin
          state_d = jdo[0] ? S_READ : S_IDLE;
        end else if (take_no_action_ocimem_a) begin
          state_d = S_READ;
        end
      end
      S_READ, S_WRITE: begin
        if (w_accept || w_timeout) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values; strobes in a busy state only raise the error flag.
  always_comb begin
    addr_d  = addr_q;
    read_d  = read_q;
    write_d = write_q;
    wdata_d = wdata_q;
    mon_d   = mon_q;
    ready_d = ready_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          write_d = 1'b1;
          ready_d = 1'b0;
        end else if (take_action_ocimem_a) begin
          addr_d  = jdo[ADDR_W+1:2];
          error_d = 1'b0;
          if (jdo[0]) begin
            read_d  = 1'b1;
            ready_d = 1'b0;
          end else begin
            ready_d = 1'b1;
          end
        end else if (take_no_action_ocimem_a) begin
          read_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      S_READ, S_WRITE: begin
        if (w_any_strobe) begin
          error_d = 1'b1;
        end
        if (w_accept) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          addr_d  = addr_q + ADDR_W'(1);
          mon_d   = (state_q == S_READ) ? mem_readdata : wdata_q;
        end else if (w_timeout) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          ready_d = 1'b1;
          error_d = 1'b1;
        end
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  assign mem_addr      = addr_q;
  assign mem_read      = read_q;
  assign mem_write     = write_q;
  assign mem_writedata = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

endmodule

`default_nettype wire

// File: tb/tb_nios_fast_oci_mon_responder.sv
// Testbench for nios_fast_oci_mon_responder: scoreboarded memory requests plus
// directed checks of MonDReg / monitor_ready / monitor_error / mem_addr.
`default_nettype none

module tb_nios_fast_oci_mon_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sa = 1'b0, sna = 1'b0, sb_w = 1'b0;
  logic [37:0] jdo = '0;
  logic [8:0]  mem_addr;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata, MonDReg;
  logic        mem_waitrequest, monitor_ready, monitor_error;

  logic [31:0] rdbase = 32'h0;
  logic [15:0] stall_cfg = 16'd0;
  logic [15:0] stall_cnt = 16'd0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] data;
    int          len;
  } exp_t;
  exp_t sbq[$];

  nios_fast_oci_mon_responder #(.ADDR_W(9), .TIMEOUT_CYCLES(4)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .take_action_ocimem_a   (sa),
    .take_no_action_ocimem_a(sna),
    .take_action_ocimem_b   (sb_w),
    .jdo                    (jdo),
    .mem_addr               (mem_addr),
    .mem_read               (mem_read),
    .mem_write              (mem_write),
    .mem_writedata          (mem_writedata),
    .mem_readdata           (mem_readdata),
    .mem_waitrequest        (mem_waitrequest),
    .MonDReg                (MonDReg),
    .monitor_ready          (monitor_ready),
    .monitor_error          (monitor_error)
  );

  always #5 clk = ~clk;

  // Slave model: stall_cfg wait cycles per request, read data = rdbase + addr.
  always @(posedge clk) begin
    if (!(mem_read || mem_write)) stall_cnt <= stall_cfg;
    else if (stall_cnt != 16'd0)  stall_cnt <= stall_cnt - 16'd1;
  end
  assign mem_waitrequest = (mem_read || mem_write) && (stall_cnt != 16'd0);
  assign mem_readdata    = rdbase + {23'd0, mem_addr};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: every request cycle compared against the scoreboard head.
  initial begin
    int cyc = 0;
    forever begin
      @(negedge clk);
      if (!reset && (mem_read || mem_write)) begin
        cyc++;
        if (sbq.size() == 0) begin
          chk("sb_unexpected_req", 32'd1, 32'd0);
        end else begin
          chk("req_kind", 32'(mem_write), 32'(sbq[0].wr));
          chk("req_addr", 32'(mem_addr), 32'(sbq[0].addr));
          if (sbq[0].wr) chk("req_wdata", mem_writedata, sbq[0].data);
          if (!mem_waitrequest) begin
            chk("req_len", 32'(cyc), 32'(sbq[0].len));
            void'(sbq.pop_front());
            cyc = 0;
          end
        end
      end else begin
        cyc = 0;
      end
    end
  end

  // kind: 0 = action_a, 1 = no_action_a, 2 = action_b
  task automatic issue(input int kind, input logic [37:0] j);
    @(negedge clk);
    jdo = j;
    @(negedge clk);
    sa   = (kind == 0);
    sna  = (kind == 1);
    sb_w = (kind == 2);
    @(negedge clk);
    sa = 1'b0; sna = 1'b0; sb_w = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!(monitor_ready && !mem_read && !mem_write) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("done_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [37:0] jaddr(input logic [8:0] a, input bit rd);
    return {27'd0, a, 1'b0, rd};
  endfunction

  function automatic logic [37:0] jdata(input logic [31:0] d);
    return {3'd0, d, 3'd0};
  endfunction

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_req",   32'({mem_read, mem_write}), 32'd0);
    chk("rst_wdata", mem_writedata, 32'd0);
    chk("rst_mon",   MonDReg, 32'd0);
    chk("rst_flags", 32'({monitor_ready, monitor_error}), 32'd0);
    reset = 1'b0;

    // Address load + read, zero wait states
    rdbase = 32'hDEADBEEF - 32'h10;
    sbq.push_back('{wr: 1'b0, addr: 9'h010, data: 32'h0, len: 1});
    issue(0, jaddr(9'h010, 1'b1));
    chk("rd_req_n1",  32'(mem_read), 32'd1);
    chk("rd_rdy_n1",  32'(monitor_ready), 32'd0);
    @(negedge clk);
    chk("rd_req_n2",  32'(mem_read), 32'd0);
    chk("rd_rdy_n2",  32'(monitor_ready), 32'd1);
    chk("rd_mon",     MonDReg, 32'hDEADBEEF);
    chk("rd_addr_inc", 32'(mem_addr), 32'h011);

    // Write with three wait states
    stall_cfg = 16'd3;
    sbq.push_back('{wr: 1'b1, addr: 9'h011, data: 32'h12345678, len: 4});
    issue(2, jdata(32'h12345678));
    chk("wr_req_n1", 32'(mem_write), 32'd1);
    wait_done();
    chk("wr_mon",  MonDReg, 32'h12345678);
    chk("wr_rdy",  32'(monitor_ready), 32'd1);
    chk("wr_addr", 32'(mem_addr), 32'h012);
    stall_cfg = 16'd0;

    // Address wrap
    issue(0, jaddr(9'h1FF, 1'b0));
    chk("ld_addr", 32'(mem_addr), 32'h1FF);
    chk("ld_rdy",  32'(monitor_ready), 32'd1);
    chk("ld_req",  32'({mem_read, mem_write}), 32'd0);
    rdbase = 32'h0BAD_0000;
    sbq.push_back('{wr: 1'b0, addr: 9'h1FF, data: 32'h0, len: 1});
    issue(1, jaddr(9'h1FF, 1'b0));
    wait_done();
    chk("wrap_addr", 32'(mem_addr), 32'h000);
    chk("wrap_mon",  MonDReg, 32'h0BAD_01FF);

    // Busy strobe during a stalled write
    stall_cfg = 16'd5;
    sbq.push_back('{wr: 1'b1, addr: 9'h000, data: 32'hA5A50F0F, len: 6});
    issue(2, jdata(32'hA5A50F0F));
    @(negedge clk);
    sna = 1'b1;
    @(negedge clk);
    sna = 1'b0;
    wait_done();
    chk("busy_err",  32'(monitor_error), 32'd1);
    chk("busy_mon",  MonDReg, 32'hA5A50F0F);
    chk("busy_addr", 32'(mem_addr), 32'h001);
    stall_cfg = 16'd0;
    issue(0, jaddr(9'h020, 1'b0));
    chk("err_clear", 32'(monitor_error), 32'd0);
    chk("err_clr_addr", 32'(mem_addr), 32'h020);

`ifdef OCI_MON_TIMEOUT_EN
    // Timeout after 4 stalled cycles
    begin
      int n = 0;
      stall_cfg = 16'hFFFF;
      sbq.push_back('{wr: 1'b0, addr: 9'h020, data: 32'h0, len: 0});
      issue(1, jaddr(9'h020, 1'b0));
      while (mem_read && n < 50) begin
        n++;
        @(negedge clk);
      end
      sbq.delete();
      chk("to_len",  32'(n), 32'd4);
      chk("to_rdy",  32'(monitor_ready), 32'd1);
      chk("to_err",  32'(monitor_error), 32'd1);
      chk("to_addr", 32'(mem_addr), 32'h020);
      chk("to_mon",  MonDReg, 32'hA5A50F0F);
      stall_cfg = 16'd0;
    end
`endif

    // Reset during a stalled read
    stall_cfg = 16'hFFFF;
    sbq.push_back('{wr: 1'b0, addr: 9'h020, data: 32'h0, len: 0});
    issue(1, jaddr(9'h020, 1'b0));
    repeat (2) @(negedge clk);
    chk("mid_req_held", 32'(mem_read), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_req",  32'(mem_read), 32'd0);
    chk("mid_rst_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_mon",  MonDReg, 32'd0);
    chk("mid_rst_flags", 32'({monitor_ready, monitor_error}), 32'd0);
    sbq.delete();
    stall_cfg = 16'd0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
